// File: rtl/q_frag_pkg.sv
// Shared definitions for the Q fragment register bank: operation modes and
// the legal width range.
package q_frag_pkg;

  localparam int unsigned Q_WIDTH_MIN = 1;
  localparam int unsigned Q_WIDTH_MAX = 32;

  typedef enum logic [1:0] {
    MODE_INT   = 2'd0,
    MODE_EXT   = 2'd1,
    MODE_SHIFT = 2'd2,
    MODE_CNT   = 2'd3
  } q_mode_t;

endpackage : q_frag_pkg

// File: rtl/q_frag_cell.sv
// One Q fragment flip-flop: async active-low reset, synchronous set (which
// outranks enable) and clock enable on the data input.
module q_frag_cell #(
  parameter logic RST_VAL = 1'b0,
  parameter logic SET_VAL = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_set,
  input  logic i_en,
  input  logic i_d,
  output logic o_q
);

  logic r_q;

  // NOTE: non-blocking assignment so every cell in the bank samples the
  // pre-edge bank value, which the shift and count paths depend on.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_q <= RST_VAL;
    end else if (i_set) begin
      r_q <= SET_VAL;
    end else if (i_en) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule : q_frag_cell

// File: rtl/q_frag_bank.sv
// WIDTH-bit Q fragment bank: shared clock/reset/set/enable, with the data
// source (CZI, QDI, serial chain or incrementer) chosen per edge by QMODE.
module q_frag_bank
  import q_frag_pkg::*;
#(
  parameter int unsigned      WIDTH           = 8,
  parameter logic [WIDTH-1:0] RST_VAL         = '0,
  parameter logic [WIDTH-1:0] SET_VAL         = '1,
  parameter bit               SHIFT_MSB_FIRST = 1'b0,
  parameter bit               CNT_SAT         = 1'b0
) (
  input  logic             QCK,
  input  logic             QRN,
  input  logic             QST,
  input  logic             QEN,
  input  logic [1:0]       QMODE,
  input  logic [WIDTH-1:0] CZI,
  input  logic [WIDTH-1:0] QDI,
  input  logic             QSI,
  output logic [WIDTH-1:0] QZ,
  output logic             QSO,
  output logic             QTC
);

  q_mode_t          w_mode;
  logic [WIDTH-1:0] w_q;
  logic [WIDTH-1:0] w_inc;
  logic [WIDTH-1:0] w_cnt;
  logic [WIDTH-1:0] w_shift;
  logic [WIDTH-1:0] w_next;
  logic             w_all_ones;

  assign w_mode     = q_mode_t'(QMODE);
  assign w_all_ones = &w_q;
  assign w_inc      = w_q + WIDTH'(1);
  assign w_cnt      = (CNT_SAT && w_all_ones) ? w_q : w_inc;

  // Serial chain; a one-bit bank simply reloads from QSI.
  if (WIDTH == 1) begin : g_shift_1
    assign w_shift = QSI;
    assign QSO     = w_q[0];
  end else if (SHIFT_MSB_FIRST) begin : g_shift_up
    assign w_shift = {w_q[WIDTH-2:0], QSI};
    assign QSO     = w_q[WIDTH-1];
  end else begin : g_shift_down
    assign w_shift = {QSI, w_q[WIDTH-1:1]};
    assign QSO     = w_q[0];
  end

  // Only the selected bus reaches w_next, so X on an idle bus stays out of QZ.
  always_comb begin
    // NOTE: default first so every path assigns w_next and no latch is built.
    w_next = w_q;
    case (w_mode)
      MODE_INT:   w_next = CZI;
      MODE_EXT:   w_next = QDI;
      MODE_SHIFT: w_next = w_shift;
      MODE_CNT:   w_next = w_cnt;
      default:    w_next = w_q;
    endcase
  end

  for (genvar g = 0; g < WIDTH; g++) begin : g_cell
    q_frag_cell #(
      .RST_VAL (RST_VAL[g]),
      .SET_VAL (SET_VAL[g])
    ) u_cell (
      .i_clk   (QCK),
      .i_rst_n (QRN),
      .i_set   (QST),
      .i_en    (QEN),
      .i_d     (w_next[g]),
      .o_q     (w_q[g])
    );
  end

  assign QZ  = w_q;
  assign QTC = (w_mode == MODE_CNT) && QEN && !QST && QRN && w_all_ones;

endmodule : q_frag_bank

// File: tb/tb_q_frag_bank.sv
// Bench for q_frag_bank: a wrapping LSB-first bank and a saturating
// MSB-first bank share one stimulus; expected QZ values go through a queue.
module tb_q_frag_bank;
  import q_frag_pkg::*;

  localparam int W = 8;

  logic         QCK = 1'b0;
  logic         QRN, QST, QEN, QSI;
  logic [1:0]   QMODE;
  logic [W-1:0] CZI, QDI;
  logic [W-1:0] qz0, qz1;
  logic         qso0, qso1, qtc0, qtc1;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    string        tag;
    logic [W-1:0] qz0;
    logic [W-1:0] qz1;
  } exp_t;

  exp_t sb[$];

  always #5 QCK = ~QCK;

  q_frag_bank #(.WIDTH(W), .SHIFT_MSB_FIRST(1'b0), .CNT_SAT(1'b0)) dut (
    .QCK(QCK), .QRN(QRN), .QST(QST), .QEN(QEN), .QMODE(QMODE),
    .CZI(CZI), .QDI(QDI), .QSI(QSI), .QZ(qz0), .QSO(qso0), .QTC(qtc0)
  );

  q_frag_bank #(.WIDTH(W), .SHIFT_MSB_FIRST(1'b1), .CNT_SAT(1'b1)) dut_sat (
    .QCK(QCK), .QRN(QRN), .QST(QST), .QEN(QEN), .QMODE(QMODE),
    .CZI(CZI), .QDI(QDI), .QSI(QSI), .QZ(qz1), .QSO(qso1), .QTC(qtc1)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge QCK);
    #1;
  endtask

  task automatic drive(logic [1:0] mode, logic st, logic en,
                       logic [W-1:0] czi, logic [W-1:0] qdi, logic qsi);
    QMODE = mode; QST = st; QEN = en; CZI = czi; QDI = qdi; QSI = qsi;
  endtask

  function automatic logic [W-1:0] model_next(logic [W-1:0] q, logic st, logic en,
      logic [1:0] mode, logic [W-1:0] czi, logic [W-1:0] qdi, logic qsi,
      bit msb, bit sat);
    if (st) return 8'hFF;
    if (!en) return q;
    case (mode)
      2'd0:    return czi;
      2'd1:    return qdi;
      2'd2:    return msb ? {q[6:0], qsi} : {qsi, q[7:1]};
      default: return (sat && q == 8'hFF) ? q : q + 8'd1;
    endcase
  endfunction

  // Loads a known value into both banks through EXT and checks it.
  task automatic preload(string tag, logic [W-1:0] v);
    exp_t e;
    drive(MODE_EXT, 1'b0, 1'b1, 8'h00, v, 1'b0);
    sb.push_back('{tag, v, v});
    tick();
    e = sb.pop_front();
    n_checks++;
    if (qz0 !== e.qz0 || qz1 !== e.qz1) begin
      n_fail++;
      $display("FAIL %s: QZ=%h/%h expected %h/%h", e.tag, qz0, qz1, e.qz0, e.qz1);
    end
  endtask

  task automatic test_reset();
    exp_t e;
    QRN = 1'b0;
    drive(MODE_INT, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    #2;
    n_checks++;
    if (qz0 !== 8'h00 || qz1 !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_init: QZ=%h/%h expected 00/00", qz0, qz1);
    end
    tick();
    tick();
    QRN = 1'b1;
    preload("pre_reset_load", 8'h5A);
    #3;
    QRN = 1'b0;
    #1;
    n_checks++;
    if (qz0 !== 8'h00 || qz1 !== 8'h00) begin
      n_fail++;
      $display("FAIL async_reset: QZ=%h/%h expected 00/00", qz0, qz1);
    end
    for (int i = 0; i < 2; i++) begin
      sb.push_back('{"reset_hold", 8'h00, 8'h00});
      tick();
      e = sb.pop_front();
      n_checks++;
      if (qz0 !== e.qz0 || qz1 !== e.qz1) begin
        n_fail++;
        $display("FAIL %s: QZ=%h/%h expected %h/%h", e.tag, qz0, qz1, e.qz0, e.qz1);
      end
    end
    QRN = 1'b1;
    QEN = 1'b0;
  endtask

  typedef struct packed {
    logic [1:0]   mode;
    logic         st;
    logic         en;
    logic [W-1:0] czi;
    logic [W-1:0] qdi;
    logic [W-1:0] exp_q;
  } ld_t;

  task automatic test_load();
    exp_t e;
    ld_t  tbl [8];
    tbl = '{
      '{MODE_INT, 1'b0, 1'b1, 8'hA5, 8'h3C, 8'hA5},
      '{MODE_EXT, 1'b0, 1'b1, 8'hA5, 8'h3C, 8'h3C},
      '{MODE_CNT, 1'b1, 1'b0, 8'hA5, 8'h3C, 8'hFF},
      '{MODE_EXT, 1'b0, 1'b0, 8'h12, 8'h34, 8'hFF},
      '{MODE_INT, 1'b0, 1'b0, 8'h12, 8'h34, 8'hFF},
      '{MODE_CNT, 1'b0, 1'b0, 8'h12, 8'h34, 8'hFF},
      '{MODE_INT, 1'b0, 1'b1, 8'h42, 8'hxx, 8'h42},
      '{MODE_EXT, 1'b0, 1'b1, 8'hxx, 8'h81, 8'h81}
    };
    for (int i = 0; i < 8; i++) begin
      drive(tbl[i].mode, tbl[i].st, tbl[i].en, tbl[i].czi, tbl[i].qdi, 1'b0);
      sb.push_back('{$sformatf("load_step%0d", i), tbl[i].exp_q, tbl[i].exp_q});
      tick();
      e = sb.pop_front();
      n_checks++;
      if (qz0 !== e.qz0 || qz1 !== e.qz1) begin
        n_fail++;
        $display("FAIL %s: QZ=%h/%h expected %h/%h", e.tag, qz0, qz1, e.qz0, e.qz1);
      end
    end
  endtask

  task automatic test_shift();
    exp_t         e;
    logic         bits [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    logic [W-1:0] exp0 [4] = '{8'h80, 8'h40, 8'hA0, 8'hD0};
    logic [W-1:0] exp1 [4] = '{8'h01, 8'h02, 8'h05, 8'h0B};
    logic [W-1:0] p0, p1;
    logic         b;
    preload("shift_preload", 8'h00);
    p0 = 8'h00;
    p1 = 8'h00;
    for (int i = 0; i < 12; i++) begin
      b = (i < 4) ? bits[i] : 1'($urandom_range(0, 1));
      if (i == 4) begin
        preload("shift_preload2", 8'h35);
        p0 = 8'h35;
        p1 = 8'h35;
      end
      drive(MODE_SHIFT, 1'b0, 1'b1, 8'h00, 8'h00, b);
      #1;
      n_checks++;
      if (qso0 !== p0[0] || qso1 !== p1[7]) begin
        n_fail++;
        $display("FAIL shift_qso%0d: QSO=%b/%b expected %b/%b", i, qso0, qso1, p0[0], p1[7]);
      end
      if (i < 4) begin
        p0 = exp0[i];
        p1 = exp1[i];
      end else begin
        p0 = {b, p0[7:1]};
        p1 = {p1[6:0], b};
      end
      sb.push_back('{$sformatf("shift%0d", i), p0, p1});
      tick();
      e = sb.pop_front();
      n_checks++;
      if (qz0 !== e.qz0 || qz1 !== e.qz1) begin
        n_fail++;
        $display("FAIL %s: QZ=%h/%h expected %h/%h", e.tag, qz0, qz1, e.qz0, e.qz1);
      end
    end
  endtask

  task automatic test_count();
    exp_t         e;
    logic [W-1:0] e0 [3] = '{8'hFF, 8'h00, 8'h01};
    logic         t0 [3] = '{1'b1, 1'b0, 1'b0};
    preload("cnt_preload", 8'hFE);
    drive(MODE_CNT, 1'b0, 1'b1, 8'h00, 8'h00, 1'b0);
    for (int i = 0; i < 3; i++) begin
      sb.push_back('{$sformatf("count%0d", i), e0[i], 8'hFF});
      tick();
      e = sb.pop_front();
      n_checks++;
      if (qz0 !== e.qz0 || qz1 !== e.qz1) begin
        n_fail++;
        $display("FAIL %s: QZ=%h/%h expected %h/%h", e.tag, qz0, qz1, e.qz0, e.qz1);
      end
      n_checks++;
      if (qtc0 !== t0[i] || qtc1 !== 1'b1) begin
        n_fail++;
        $display("FAIL count_qtc%0d: QTC=%b/%b expected %b/1", i, qtc0, qtc1, t0[i]);
      end
    end
    preload("cnt_preload_ff", 8'hFF);
    QMODE = MODE_CNT;
    #1;
    n_checks++;
    if (qtc0 !== 1'b1) begin
      n_fail++;
      $display("FAIL qtc_at_ff: QTC=%b expected 1", qtc0);
    end
    QEN = 1'b0;
    #1;
    n_checks++;
    if (qtc0 !== 1'b0 || qtc1 !== 1'b0) begin
      n_fail++;
      $display("FAIL qtc_en_low: QTC=%b/%b expected 0/0", qtc0, qtc1);
    end
  endtask

  task automatic test_mode_switch();
    exp_t         e;
    logic [1:0]   mode [3] = '{MODE_CNT, MODE_EXT, MODE_CNT};
    logic         st   [3] = '{1'b0, 1'b0, 1'b1};
    logic [W-1:0] ex   [3] = '{8'h21, 8'h11, 8'hFF};
    preload("mode_preload", 8'h20);
    for (int i = 0; i < 3; i++) begin
      if (i == 2) preload("mode_preload_ff", 8'hFF);
      drive(mode[i], st[i], 1'b1, 8'h00, 8'h11, 1'b0);
      sb.push_back('{$sformatf("mode_switch%0d", i), ex[i], ex[i]});
      tick();
      e = sb.pop_front();
      n_checks++;
      if (qz0 !== e.qz0 || qz1 !== e.qz1) begin
        n_fail++;
        $display("FAIL %s: QZ=%h/%h expected %h/%h", e.tag, qz0, qz1, e.qz0, e.qz1);
      end
    end
    n_checks++;
    if (qtc0 !== 1'b0 || qtc1 !== 1'b0) begin
      n_fail++;
      $display("FAIL qtc_set_high: QTC=%b/%b expected 0/0", qtc0, qtc1);
    end
    QST = 1'b0;
    #1;
    n_checks++;
    if (qtc0 !== 1'b1 || qtc1 !== 1'b1) begin
      n_fail++;
      $display("FAIL qtc_set_low: QTC=%b/%b expected 1/1", qtc0, qtc1);
    end
  endtask

  task automatic test_back_to_back();
    exp_t         e;
    logic [W-1:0] m0, m1, czi, qdi;
    logic [1:0]   mode;
    logic         st, en, qsi, tc0, tc1;
    preload("b2b_preload", 8'hFC);
    m0 = 8'hFC;
    m1 = 8'hFC;
    for (int i = 0; i < 60; i++) begin
      mode = 2'($urandom_range(0, 3));
      st   = ($urandom_range(0, 9) == 0);
      en   = ($urandom_range(0, 3) != 0);
      czi  = 8'($urandom);
      qdi  = 8'($urandom);
      qsi  = 1'($urandom_range(0, 1));
      if (i % 8 < 5) mode = MODE_CNT;
      drive(mode, st, en, czi, qdi, qsi);
      #1;
      tc0 = (mode == 2'd3) && en && !st && (m0 == 8'hFF);
      tc1 = (mode == 2'd3) && en && !st && (m1 == 8'hFF);
      n_checks++;
      if (qtc0 !== tc0 || qtc1 !== tc1 || qso0 !== m0[0] || qso1 !== m1[7]) begin
        n_fail++;
        $display("FAIL b2b_comb%0d: QTC=%b/%b QSO=%b/%b expected QTC=%b/%b QSO=%b/%b",
                 i, qtc0, qtc1, qso0, qso1, tc0, tc1, m0[0], m1[7]);
      end
      m0 = model_next(m0, st, en, mode, czi, qdi, qsi, 1'b0, 1'b0);
      m1 = model_next(m1, st, en, mode, czi, qdi, qsi, 1'b1, 1'b1);
      sb.push_back('{$sformatf("b2b%0d", i), m0, m1});
      tick();
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL b2b_queue: scoreboard empty at step %0d", i);
      end else begin
        e = sb.pop_front();
        n_checks++;
        if (qz0 !== e.qz0 || qz1 !== e.qz1) begin
          n_fail++;
          $display("FAIL %s: QZ=%h/%h expected %h/%h", e.tag, qz0, qz1, e.qz0, e.qz1);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_shift();
    test_count();
    test_mode_switch();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_q_frag_bank
